// File: rtl/hilo_md_if.sv
// EX-stage bundle between the pipeline and the HI/LO multiply/divide sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface hilo_md_if;
  logic        flush;
  logic        valid_e;
  logic [4:0]  alucontrol_e;
  logic [31:0] a_e;
  logic [31:0] b_e;
  logic        stall_md;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output flush, valid_e, alucontrol_e, a_e, b_e,
    input  stall_md, busy, hi_o, lo_o
  );

  modport slave (
    input  flush, valid_e, alucontrol_e, a_e, b_e,
    output stall_md, busy, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_md_ctrl.sv
// Multiply/divide sequencer and owner of the architectural HI/LO registers.
// Runs MULT/MULTU over MUL_CYCLES and DIV/DIVU as a 32-step restoring divider.
//
// state  | meaning
// S_IDLE | ready; accepts mult/div starts and MTHI/MTLO writes
// S_MUL  | multiplier settling, product captured when cnt reaches 0
// S_DIV  | one shift-subtract step per cycle on operand magnitudes
// S_FIN  | result ready; HI/LO written at the edge that ends this state
module hilo_md_ctrl #(
  parameter int unsigned MUL_CYCLES    = 2,
  parameter logic [4:0]  MULT_CONTROL  = 5'h11,
  parameter logic [4:0]  MULTU_CONTROL = 5'h12,
  parameter logic [4:0]  DIV_CONTROL   = 5'h13,
  parameter logic [4:0]  DIVU_CONTROL  = 5'h14,
  parameter logic [4:0]  MTHI_CONTROL  = 5'h15,
  parameter logic [4:0]  MTLO_CONTROL  = 5'h16
) (
  input logic      clk,
  input logic      resetn,
  hilo_md_if.slave md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        is_div_q, sgn_q, neg_quo_q, neg_rem_q;

  logic op_mul, op_div, op_sgn, start, a_neg, b_neg;

  assign op_mul = (md.alucontrol_e == MULT_CONTROL) || (md.alucontrol_e == MULTU_CONTROL);
  assign op_div = (md.alucontrol_e == DIV_CONTROL)  || (md.alucontrol_e == DIVU_CONTROL);
  assign op_sgn = (md.alucontrol_e == MULT_CONTROL) || (md.alucontrol_e == DIV_CONTROL);
  assign a_neg  = op_sgn & md.a_e[31];
  assign b_neg  = op_sgn & md.b_e[31];
  assign start  = md.valid_e & ~md.flush & (state_q == S_IDLE) & (op_mul | op_div);

  assign md.stall_md = ~md.flush & (start | (state_q == S_MUL) | (state_q == S_DIV));
  assign md.busy     = (state_q != S_IDLE);
  assign md.hi_o     = hi_q;
  assign md.lo_o     = lo_q;

  // 64-bit operands so the low 64 bits of the product are right for both signednesses
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{sgn_q & quo_q[31]}}, quo_q};
  assign mul_b = {{32{sgn_q & dvs_q[31]}}, dvs_q};
  assign prod  = mul_a * mul_b;

  logic [32:0] shl, trial;
  logic [31:0] rem_d, quo_d;
  assign shl   = {rem_q, quo_q[31]};
  assign trial = shl - {1'b0, dvs_q};
  assign rem_d = trial[32] ? shl[31:0] : trial[31:0];
  assign quo_d = {quo_q[30:0], ~trial[32]};

  // Divide by zero leaves rem=|a| (sign fix restores a) but the quotient must stay all ones
  logic [31:0] hi_fin, lo_fin;
  always_comb begin
    hi_fin = rem_q;
    lo_fin = quo_q;
    if (is_div_q) begin
      if (neg_rem_q) hi_fin = -rem_q;
      if (dvs_q == '0)    lo_fin = '1;
      else if (neg_quo_q) lo_fin = -quo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_div_q  <= 1'b0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (md.flush) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= op_div ? S_DIV : S_MUL;
            cnt_q     <= op_div ? 5'd31 : 5'(MUL_CYCLES - 1);
            is_div_q  <= op_div;
            sgn_q     <= op_sgn;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_q     <= '0;
            quo_q     <= (op_div & a_neg) ? -md.a_e : md.a_e;
            dvs_q     <= (op_div & b_neg) ? -md.b_e : md.b_e;
          end else if (md.valid_e && md.alucontrol_e == MTHI_CONTROL) begin
            hi_q <= md.a_e;
          end else if (md.valid_e && md.alucontrol_e == MTLO_CONTROL) begin
            lo_q <= md.a_e;
          end
        end
        S_MUL: begin
          if (cnt_q == '0) begin
            {rem_q, quo_q} <= prod;
            state_q        <= S_FIN;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= S_FIN;
        end
        S_FIN: begin
          hi_q    <= hi_fin;
          lo_q    <= lo_fin;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
